// File: rtl/peripheral_sum_accumulator.sv
// Reduction stage: sums a programmable-length block of adder outputs into a saturating
// accumulator and presents the block total plus a sticky saturation flag over valid/ready.
module peripheral_sum_accumulator #(
   parameter int DATA_WIDTH  = 9,
   parameter int ACC_WIDTH   = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [COUNT_WIDTH-1:0] cfg_len,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [ACC_WIDTH-1:0]   out_data,
   output logic                   out_sat,
   input  logic                   out_ready,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]             state_r;
   logic [1:0]             state_nxt_s;
   logic [ACC_WIDTH-1:0]   acc_r;
   logic [COUNT_WIDTH-1:0] cnt_r;
   logic [COUNT_WIDTH-1:0] len_r;
   logic                   sat_r;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic                   busy_r;
   logic                   accept_s;
   logic                   last_s;
   logic                   load_s;
   logic [ACC_WIDTH:0]     sum_s;

   // Returns {clamped, value}; the top bit doubles as the saturation indication.
   function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      logic [ACC_WIDTH:0] s;
      s = {1'b0, a} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, b};
      if (s[ACC_WIDTH]) begin
         sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
      end else begin
         sat_add = s;
      end
   endfunction

   assign accept_s = in_valid && (state_r == ST_ACCUM);
   assign last_s   = (cnt_r == (len_r - {{(COUNT_WIDTH-1){1'b0}}, 1'b1}));
   assign load_s   = start && ((state_r == ST_IDLE) ||
                               ((state_r == ST_HOLD) && out_ready));
   assign sum_s    = sat_add(acc_r, in_data);

   // Next-state selection for the block sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_ACCUM;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (accept_s && last_s) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_nxt_s = start ? ST_ACCUM : ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, datapath and flag registers; handshake flags are precomputed from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         acc_r       <= {ACC_WIDTH{1'b0}};
         cnt_r       <= {COUNT_WIDTH{1'b0}};
         len_r       <= {COUNT_WIDTH{1'b0}};
         sat_r       <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= (state_nxt_s == ST_ACCUM);
         out_valid_r <= (state_nxt_s == ST_HOLD);
         busy_r      <= (state_nxt_s != ST_IDLE);
         if (load_s) begin
            // A zero length is promoted to one so the block always terminates.
            len_r <= (cfg_len == {COUNT_WIDTH{1'b0}}) ?
                     {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : cfg_len;
            acc_r <= {ACC_WIDTH{1'b0}};
            cnt_r <= {COUNT_WIDTH{1'b0}};
            sat_r <= 1'b0;
         end else if (accept_s) begin
            acc_r <= sum_s[ACC_WIDTH-1:0];
            sat_r <= sat_r | sum_s[ACC_WIDTH];
            cnt_r <= cnt_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            acc_r <= acc_r;
            sat_r <= sat_r;
            cnt_r <= cnt_r;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = acc_r;
   assign out_sat   = sat_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_peripheral_sum_accumulator.sv
// Scoreboard bench: expected block results are queued at stimulus time and popped by a
// monitor on every output handshake; control-flag checks are made inline.
module tb_peripheral_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cfg_len;
   logic        start;
   logic        in_valid;
   logic [8:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_sat;
   logic        out_ready;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;
   logic [16:0] exp_q[$];

   peripheral_sum_accumulator dut (
      .clk(clk), .rst(rst), .cfg_len(cfg_len), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every accepted result must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: got data=%0d sat=%0d expected none",
                     out_data, out_sat);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({out_sat, out_data} !== e) begin
               miscompares++;
               $display("FAIL block_result: got data=%0d sat=%0d expected data=%0d sat=%0d",
                        out_data, out_sat, e[15:0], e[16]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_block(input logic [7:0] l);
      cfg_len = l;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      check("in_ready_after_start", 32'(in_ready), 32'd1);
   endtask

   task automatic feed(input logic [8:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic release_result;
      check("out_valid_latency", 32'(out_valid), 32'd1);
      check("in_ready_in_hold", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_after_ack", 32'(out_valid), 32'd0);
      check("busy_after_ack", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cfg_len = 8'd0; start = 1'b0; in_valid = 1'b0;
      in_data = 9'd0; out_ready = 1'b0;
      tick(); tick();
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      // 1: basic block of four
      exp_q.push_back({1'b0, 16'd1111});
      begin_block(8'd4);
      feed(9'd100); feed(9'd200); feed(9'd300);
      check("no_early_valid", 32'(out_valid), 32'd0);
      feed(9'd511);
      check("busy_in_hold", 32'(busy), 32'd1);
      release_result();

      // 2: saturation, then sticky flag cleared by next block
      exp_q.push_back({1'b1, 16'd65535});
      begin_block(8'd200);
      repeat (200) feed(9'd511);
      release_result();
      exp_q.push_back({1'b0, 16'd30});
      begin_block(8'd3);
      repeat (3) feed(9'd10);
      release_result();

      // 3: bubbles and backpressure
      exp_q.push_back({1'b0, 16'd18});
      begin_block(8'd3);
      feed(9'd5);
      tick(); tick();
      feed(9'd6); feed(9'd7);
      in_valid = 1'b1; in_data = 9'd99;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data", 32'(out_data), 32'd18);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      release_result();

      // 4: zero length behaves as one
      exp_q.push_back({1'b0, 16'd42});
      begin_block(8'd0);
      feed(9'd42);
      release_result();

      // 5: reset mid-block
      begin_block(8'd5);
      feed(9'd50); feed(9'd60);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_out_sat", 32'(out_sat), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      exp_q.push_back({1'b0, 16'd7});
      begin_block(8'd1);
      feed(9'd7);
      release_result();

      // 6: back-to-back blocks via start during the output handshake
      exp_q.push_back({1'b0, 16'd5});
      begin_block(8'd2);
      feed(9'd2); feed(9'd3);
      check("b2b_first_valid", 32'(out_valid), 32'd1);
      exp_q.push_back({1'b0, 16'd3});
      cfg_len = 8'd2; start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0; out_ready = 1'b0;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_out_valid", 32'(out_valid), 32'd0);
      feed(9'd1); feed(9'd2);
      release_result();

      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
